// File: rtl/clock_pkg.sv
// +-----------------------------------------------------------------------+
// | clock_pkg : shared states, select codes and BCD constants for clock   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HOUR = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_SEC  = 2'd3;

    localparam logic [7:0] BCD_51 = 8'h51;
    localparam logic [7:0] BCD_53 = 8'h53;
    localparam logic [7:0] BCD_55 = 8'h55;
    localparam logic [7:0] BCD_57 = 8'h57;
    localparam logic [7:0] BCD_59 = 8'h59;

    function automatic logic [1:0] sel_of(input state_t s);
        case (s)
            SET_H:   sel_of = SEL_HOUR;
            SET_M:   sel_of = SEL_MIN;
            SET_S:   sel_of = SEL_SEC;
            default: sel_of = SEL_NONE;
        endcase
    endfunction

    function automatic logic is_lo_second(input logic [7:0] s);
        is_lo_second = (s == BCD_51) || (s == BCD_53) ||
                       (s == BCD_55) || (s == BCD_57);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_ctrl_key_edge.sv
// +-----------------------------------------------------------------------+
// | key_edge : rising-edge detector for a debounced key level             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module key_edge (
    input  logic CP,
    input  logic nCR,
    input  logic key,
    output logic rise
);

    logic hist;

    // History resets to 1 so a key held through reset gives no edge.
    always_ff @(posedge CP) begin
        if (!nCR) hist <= 1'b1;
        else      hist <= key;
    end

    assign rise = key & ~hist;

endmodule

`default_nettype wire

// File: rtl/clock_ctrl.sv
// +-----------------------------------------------------------------------+
// | clock_ctrl : enable/carry sequencer, time-set FSM and chime for clock |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module clock_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT = 30,
    parameter int TO_W    = 6
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       tick,
    input  logic       key_mode,
    input  logic       key_adj,
    input  logic [7:0] Sec,
    input  logic [7:0] Min,
    output logic       EN_S,
    output logic       EN_M,
    output logic       EN_H,
    output logic       sec_clr_n,
    output logic [1:0] sel,
    output logic       blink,
    output logic       chime_lo,
    output logic       chime_hi
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic            mode_rise;
    logic            adj_rise;
    logic            adj_ev;
    logic            in_set;
    logic            to_fire;
    logic            changed;
    state_t          state;
    state_t          state_nx;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nx;
    logic            blink_nx;
    logic            en_s_nx;
    logic            en_m_nx;
    logic            en_h_nx;
    logic            clr_n_nx;
    logic            lo_nx;
    logic            hi_nx;
    logic            carry_m;
    logic            carry_h;

    key_edge u_mode_edge (
        .CP   (CP),
        .nCR  (nCR),
        .key  (key_mode),
        .rise (mode_rise)
    );

    key_edge u_adj_edge (
        .CP   (CP),
        .nCR  (nCR),
        .key  (key_adj),
        .rise (adj_rise)
    );

    always_ff @(posedge CP) begin
        if (!nCR) begin
            state     <= RUN;
            to_cnt    <= '0;
            EN_S      <= 1'b0;
            EN_M      <= 1'b0;
            EN_H      <= 1'b0;
            sec_clr_n <= 1'b1;
            sel       <= SEL_NONE;
            blink     <= 1'b0;
            chime_lo  <= 1'b0;
            chime_hi  <= 1'b0;
        end else begin
            state     <= state_nx;
            to_cnt    <= to_cnt_nx;
            EN_S      <= en_s_nx;
            EN_M      <= en_m_nx;
            EN_H      <= en_h_nx;
            sec_clr_n <= clr_n_nx;
            sel       <= sel_of(state_nx);
            blink     <= blink_nx;
            chime_lo  <= lo_nx;
            chime_hi  <= hi_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        to_cnt_nx = to_cnt;
        blink_nx  = 1'b0;
        en_s_nx   = 1'b0;
        en_m_nx   = 1'b0;
        en_h_nx   = 1'b0;
        clr_n_nx  = 1'b1;
        lo_nx     = 1'b0;
        hi_nx     = 1'b0;

        // Mode wins over adjust when both keys rise together.
        adj_ev  = adj_rise & ~mode_rise;
        in_set  = (state != RUN);
        to_fire = in_set && tick && (to_cnt == TO_LAST) && !mode_rise && !adj_ev;
        carry_m = tick && (Sec == BCD_59);
        carry_h = carry_m && (Min == BCD_59);

        case (state)
            RUN: begin
                if (mode_rise) state_nx = SET_H;
                en_s_nx = tick;
                en_m_nx = carry_m;
                en_h_nx = carry_h;
            end
            SET_H: begin
                if (mode_rise)    state_nx = SET_M;
                else if (to_fire) state_nx = RUN;
                en_h_nx = adj_ev;
            end
            SET_M: begin
                if (mode_rise)    state_nx = SET_S;
                else if (to_fire) state_nx = RUN;
                en_m_nx = adj_ev;
            end
            default: begin
                if (mode_rise || to_fire) state_nx = RUN;
                clr_n_nx = ~adj_ev;
            end
        endcase

        changed = (state_nx != state);

        if (changed || mode_rise || adj_ev) to_cnt_nx = '0;
        else if (in_set && tick)            to_cnt_nx = to_cnt + 1'b1;

        if (!changed && in_set) blink_nx = tick ? ~blink : blink;

        // Chime only while running, judged on the counters' current values.
        if (state_nx == RUN && Min == BCD_59) begin
            lo_nx = is_lo_second(Sec);
            hi_nx = (Sec == BCD_59);
        end
    end

endmodule

`default_nettype wire

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Mode and enable sequencer for the digital clock's BCD time-of-day datapath: seconds (mod-60), minutes (mod-60) and hours (counter24, mod-24).
- Converts a 1 Hz tick into per-field count-enable pulses with carry sequencing.
- Runs a time-set FSM driven by two debounced keys.
- Generates the hourly chime and the set-mode blink/select outputs for the display path.
- Sits between the prescaler/key debouncers and the three counters.

Parameters:
TIMEOUT, 30, number of ticks with no key edge in a set state before automatic return to RUN
TO_W, 6, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT

Ports:
CP  input  1  system clock; all state changes on the rising edge
nCR  input  1  reset, synchronous, active-low
tick  input  1  one-CP-cycle 1 Hz pulse; consecutive ticks are at least 4 CP cycles apart
key_mode  input  1  debounced mode key, active-high level
key_adj  input  1  debounced adjust key, active-high level
Sec  input  8  current seconds, BCD {tens,units}
Min  input  8  current minutes, BCD {tens,units}
EN_S  output  1  seconds counter enable, one-cycle pulse
EN_M  output  1  minutes counter enable, one-cycle pulse
EN_H  output  1  hours counter enable, one-cycle pulse
sec_clr_n  output  1  seconds clear, active-low, one-cycle pulse
sel  output  2  field being set: 0 none, 1 hour, 2 min, 3 sec
blink  output  1  display blank phase for the selected field
chime_lo  output  1  low-tone chime enable
chime_hi  output  1  high-tone chime enable

Behaviour:
- Reset: on a CP edge with nCR=0, all of the following take their reset values:
  - state=RUN; EN_S=EN_M=EN_H=0; sec_clr_n=1; sel=0; blink=0; chime_lo=chime_hi=0; timeout count=0.
  - Both key-history registers load 1, so a key held through reset produces no edge.
  - Reset mid-operation returns to RUN immediately, with no partial pulse.
- Key edges: a rising edge means the key is 1 this cycle and was 0 in the previous sampled cycle. Edges are internal, one cycle long.
- FSM states: RUN, SET_H, SET_M, SET_S.
  - Mode edge: RUN->SET_H->SET_M->SET_S->RUN.
  - Timeout: any set state returns to RUN.
  - If mode and adj edges occur in the same cycle, the mode edge wins and the adj edge is discarded.
- All outputs are registered. A pulse appears in the cycle after the triggering tick or edge and lasts exactly 1 cycle.
- RUN state:
  - On tick: EN_S=1.
  - Same tick with Sec==8'h59: EN_M=1.
  - Same tick with Sec==8'h59 and Min==8'h59: EN_H=1.
  - Sec and Min are sampled in the tick cycle, before the counters update.
- SET states:
  - Ticks generate no EN_S, EN_M or EN_H; time is frozen.
  - SET_H: adj edge gives EN_H=1 only. The hour wraps 23->00 inside the counter; no carry to any other field.
  - SET_M: adj edge gives EN_M=1 only. The minute counter wraps 59->00; no hour carry.
  - SET_S: adj edge gives sec_clr_n=0 for one cycle.
- sel and blink:
  - sel follows the state, registered (RUN=0, SET_H=1, SET_M=2, SET_S=3).
  - blink toggles on each tick while in a set state.
  - blink is forced to 0 in RUN and is cleared on every state change.
- Timeout:
  - The counter clears on state entry and on any mode or adj edge.
  - It increments on each tick in a set state.
  - When a tick arrives with count==TIMEOUT-1, the next state is RUN and the counter clears.
  - If an adj edge and the timeout tick coincide, the edge is honoured, the counter clears and the state stays.
- Chime (RUN state only), evaluated each cycle on registered Min and Sec:
  - chime_lo=1 when Min==8'h59 and Sec is one of 8'h51, 8'h53, 8'h55, 8'h57.
  - chime_hi=1 when Min==8'h59 and Sec==8'h59.
  - Both are 0 otherwise and in all set states.
- Non-BCD or out-of-range Sec/Min inputs: compare as raw bytes, so no carry or chime is produced.

Decomposition:
- Shared package clock_pkg:
  - State encodings RUN/SET_H/SET_M/SET_S (2-bit).
  - sel codes.
  - BCD constants BCD_59=8'h59, BCD_51/53/55/57.
- One sub-module, key_edge (clock CP, sync reset nCR, history reset to 1). It is instantiated once for key_mode and once for key_adj.

Test Plan:
- Reset with key_mode held at 1, then release, then tick -> no state change; EN_S=1 one cycle after the tick; sel=0.
- RUN, Sec=8'h59, Min=8'h59, tick -> EN_S, EN_M and EN_H all 1 in the same cycle; Sec=8'h58 -> EN_S only.
- Three mode edges then adj: adj in SET_H -> EN_H pulse; in SET_M -> EN_M pulse; in SET_S -> sec_clr_n=0 for one cycle; sel goes 1,2,3; a fourth mode edge -> RUN, sel=0.
- SET_M with 30 ticks and no keys -> RUN after the 30th tick; blink toggled 29 times and then 0. With an adj edge at tick 29 -> still SET_M and the count restarts.
- Min=8'h59 with Sec swept 8'h50..8'h59 in RUN -> chime_lo high at 51/53/55/57, chime_hi high at 59; same sweep in SET_H -> both 0.
- Mode and adj rising in the same cycle in SET_H -> state SET_M, no EN_H; nCR=0 asserted mid-SET_S -> RUN with all outputs at reset values next cycle.
